// File: rtl/divekick_pkg.sv
// Shared Divekick definitions: game state codes, winner codes and field widths.
// Imported by the match FSM, the round/pause timers and the HUD.
package divekick_pkg;

  localparam int STATE_W  = 4;
  localparam int SCORE_W  = 2;
  localparam int ROUND_W  = 3;
  localparam int WINNER_W = 2;
  localparam int SECS_W   = 4;
  localparam int PAUSE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    TITLE      = 4'b0000,
    PLAY       = 4'b0011,
    SETUP      = 4'b0101,
    KO_PAUSE   = 4'b0110,
    ROUND_END  = 4'b1000,
    INTRO      = 4'b1001,
    MATCH_OVER = 4'b1010
  } game_state_e;

  typedef enum logic [WINNER_W-1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  function automatic winner_e match_winner(input logic [SCORE_W-1:0] a,
                                           input logic [SCORE_W-1:0] b);
    if (a > b) begin
      return P1;
    end else if (b > a) begin
      return P2;
    end else begin
      return DRAW;
    end
  endfunction

endpackage

// File: rtl/game_state_fsm_if.sv
// Match FSM bus: timer/collision/start inputs and the state, score and winner outputs.
interface game_state_fsm_if;
  import divekick_pkg::*;

  logic                StartKey;
  logic                P1Hit;
  logic                P2Hit;
  logic [SECS_W-1:0]   round_time;
  logic [PAUSE_W-1:0]  ko_time;
  logic [PAUSE_W-1:0]  end_time;
  logic [PAUSE_W-1:0]  intro_time;
  game_state_e         GameState;
  logic [SCORE_W-1:0]  P1Score;
  logic [SCORE_W-1:0]  P2Score;
  logic [ROUND_W-1:0]  RoundNum;
  winner_e             RoundWinner;
  winner_e             MatchWinner;

  modport master (
    output StartKey, P1Hit, P2Hit, round_time, ko_time, end_time, intro_time,
    input  GameState, P1Score, P2Score, RoundNum, RoundWinner, MatchWinner
  );

  modport slave (
    input  StartKey, P1Hit, P2Hit, round_time, ko_time, end_time, intro_time,
    output GameState, P1Score, P2Score, RoundNum, RoundWinner, MatchWinner
  );

endinterface

// File: rtl/game_state_fsm_rising_edge_det.sv
// Single-cycle rising-edge pulse on a level input; delayed bit resets to RESET_VAL
// so a level already high when reset releases does not count as an edge.
module rising_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Delayed copy of the input
  always_ff @(posedge Clk) begin
    if (Reset) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_state_fsm.sv
// Divekick match-level FSM: sequences title/setup/intro/play/pauses/match-over and
// keeps round number, per-player round wins and round/match winners.
module game_state_fsm
  import divekick_pkg::*;
#(
  parameter logic [SCORE_W-1:0] WIN_ROUNDS   = 2'd3,
  parameter logic [ROUND_W-1:0] MAX_ROUNDS   = 3'd7,
  parameter logic [PAUSE_W-1:0] KO_SECS      = 2'd2,
  parameter logic [PAUSE_W-1:0] END_SECS     = 2'd2,
  parameter logic [PAUSE_W-1:0] INTRO_HALVES = 2'd3
) (
  input  logic            Clk,
  input  logic            Reset,
  game_state_fsm_if.slave bus
);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [ROUND_W-1:0] round_q, round_d;
  winner_e            rwin_q, rwin_d, mwin_q, mwin_d;
  logic               start_edge;

  rising_edge_det #(.RESET_VAL(1'b1)) u_start_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (bus.StartKey),
    .rise  (start_edge)
  );

  // Next state, scores, round counter and winners
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    round_d = round_q;
    rwin_d  = rwin_q;
    mwin_d  = mwin_q;
    case (state_q)
      TITLE: begin
        if (start_edge) begin
          state_d = SETUP;
          p1_d    = 2'd0;
          p2_d    = 2'd0;
          round_d = 3'd1;
          rwin_d  = NONE;
          mwin_d  = NONE;
        end else begin
          state_d = TITLE;
        end
      end
      SETUP: state_d = INTRO;
      INTRO: begin
        if (bus.intro_time == INTRO_HALVES) begin
          state_d = PLAY;
          rwin_d  = NONE;
        end else begin
          state_d = INTRO;
        end
      end
      // A hit in the same cycle as the timeout wins over the timeout
      PLAY: begin
        if (bus.P1Hit && bus.P2Hit) begin
          state_d = KO_PAUSE;
          rwin_d  = DRAW;
        end else if (bus.P1Hit) begin
          state_d = KO_PAUSE;
          rwin_d  = P1;
          p1_d    = sat_inc(p1_q);
        end else if (bus.P2Hit) begin
          state_d = KO_PAUSE;
          rwin_d  = P2;
          p2_d    = sat_inc(p2_q);
        end else if (bus.round_time == 4'd0) begin
          state_d = ROUND_END;
          rwin_d  = DRAW;
        end else begin
          state_d = PLAY;
        end
      end
      KO_PAUSE: begin
        if (bus.ko_time != KO_SECS) begin
          state_d = KO_PAUSE;
        end else if (p1_q == WIN_ROUNDS || p2_q == WIN_ROUNDS) begin
          state_d = MATCH_OVER;
          mwin_d  = match_winner(p1_q, p2_q);
        end else begin
          state_d = ROUND_END;
        end
      end
      ROUND_END: begin
        if (bus.end_time != END_SECS) begin
          state_d = ROUND_END;
        end else if (round_q == MAX_ROUNDS) begin
          state_d = MATCH_OVER;
          mwin_d  = match_winner(p1_q, p2_q);
        end else begin
          state_d = SETUP;
          round_d = round_q + 3'd1;
        end
      end
      MATCH_OVER: begin
        if (start_edge) begin
          state_d = TITLE;
          p1_d    = 2'd0;
          p2_d    = 2'd0;
          round_d = 3'd0;
          rwin_d  = NONE;
          mwin_d  = NONE;
        end else begin
          state_d = MATCH_OVER;
        end
      end
      default: begin
        state_d = TITLE;
        p1_d    = 2'd0;
        p2_d    = 2'd0;
        round_d = 3'd0;
        rwin_d  = NONE;
        mwin_d  = NONE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= TITLE;
      p1_q    <= 2'd0;
      p2_q    <= 2'd0;
      round_q <= 3'd0;
      rwin_q  <= NONE;
      mwin_q  <= NONE;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      round_q <= round_d;
      rwin_q  <= rwin_d;
      mwin_q  <= mwin_d;
    end
  end

  assign bus.GameState   = state_q;
  assign bus.P1Score     = p1_q;
  assign bus.P2Score     = p2_q;
  assign bus.RoundNum    = round_q;
  assign bus.RoundWinner = rwin_q;
  assign bus.MatchWinner = mwin_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Bench for game_state_fsm: directed vector table, hand-written match sequences and
// randomized stimulus checked against a rule-level reference model.
module tb_game_state_fsm;

  localparam int T_TITLE = 0, T_PLAY = 3, T_SETUP = 5, T_KO = 6;
  localparam int T_RE = 8, T_INTRO = 9, T_MO = 10;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  game_state_fsm_if ifc ();

  game_state_fsm #(
    .WIN_ROUNDS(2'd3), .MAX_ROUNDS(3'd7), .KO_SECS(2'd2), .END_SECS(2'd2), .INTRO_HALVES(2'd3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  bit key_lvl = 1'b0;

  // reference model state
  int m_st, m_s1, m_s2, m_rn, m_rw, m_mw;
  bit m_key_q;

  typedef struct {
    bit key, h1, h2;
    int rt, ko, et, it;
    int st, s1, s2, rn, rw, mw;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit key, bit h1, bit h2, int rt, int ko, int et, int it,
                              int st, int s1, int s2, int rn, int rw, int mw);
    vec_t v;
    v.key = key; v.h1 = h1; v.h2 = h2; v.rt = rt; v.ko = ko; v.et = et; v.it = it;
    v.st = st; v.s1 = s1; v.s2 = s2; v.rn = rn; v.rw = rw; v.mw = mw;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int winner_of(int a, int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  // Rule-level model: one call per clock with the inputs seen at that edge
  task automatic model_step(input bit rst, input bit key, input bit h1, input bit h2,
                            input int rt, input int ko, input int et, input int it);
    bit edge_s;
    int was;
    if (rst) begin
      m_st = T_TITLE; m_s1 = 0; m_s2 = 0; m_rn = 0; m_rw = 0; m_mw = 0; m_key_q = 1'b1;
      return;
    end
    edge_s = key && !m_key_q;
    m_key_q = key;
    was = m_st;
    if (m_st == T_TITLE) begin
      if (edge_s) begin
        m_st = T_SETUP; m_s1 = 0; m_s2 = 0; m_rn = 1; m_rw = 0; m_mw = 0;
      end
    end else if (m_st == T_SETUP) begin
      m_st = T_INTRO;
    end else if (m_st == T_INTRO) begin
      if (it == 3) begin m_st = T_PLAY; m_rw = 0; end
    end else if (m_st == T_PLAY) begin
      if (h1 || h2) begin
        m_st = T_KO;
        m_rw = (h1 ? 1 : 0) + (h2 ? 2 : 0);
        if (h1 && !h2) m_s1 = (m_s1 >= 3) ? 3 : m_s1 + 1;
        if (h2 && !h1) m_s2 = (m_s2 >= 3) ? 3 : m_s2 + 1;
      end else if (rt == 0) begin
        m_st = T_RE; m_rw = 3;
      end
    end else if (m_st == T_KO) begin
      if (ko == 2) m_st = (m_s1 == 3 || m_s2 == 3) ? T_MO : T_RE;
    end else if (m_st == T_RE) begin
      if (et == 2) begin
        if (m_rn == 7) m_st = T_MO;
        else begin m_st = T_SETUP; m_rn++; end
      end
    end else if (m_st == T_MO) begin
      if (edge_s) begin
        m_st = T_TITLE; m_s1 = 0; m_s2 = 0; m_rn = 0; m_rw = 0; m_mw = 0;
      end
    end else begin
      m_st = T_TITLE;
    end
    if (m_st == T_MO && was != T_MO) m_mw = winner_of(m_s1, m_s2);
  endtask

  task automatic drive(input bit rst, input bit key, input bit h1, input bit h2,
                       input int rt, input int ko, input int et, input int it);
    Reset = rst;
    key_lvl = key;
    ifc.StartKey = key;
    ifc.P1Hit = h1;
    ifc.P2Hit = h2;
    ifc.round_time = rt[3:0];
    ifc.ko_time = ko[1:0];
    ifc.end_time = et[1:0];
    ifc.intro_time = it[1:0];
    model_step(rst, key, h1, h2, rt, ko, et, it);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/state"}, int'(ifc.GameState), m_st);
    chk({tag, "/p1score"}, int'(ifc.P1Score), m_s1);
    chk({tag, "/p2score"}, int'(ifc.P2Score), m_s2);
    chk({tag, "/round"}, int'(ifc.RoundNum), m_rn);
    chk({tag, "/roundwin"}, int'(ifc.RoundWinner), m_rw);
    chk({tag, "/matchwin"}, int'(ifc.MatchWinner), m_mw);
  endtask

  // one cycle that satisfies the exit condition of the current pause, otherwise idles
  task automatic advance();
    int ko, et, it;
    ko = (m_st == T_KO) ? 2 : 0;
    et = (m_st == T_RE) ? 2 : 0;
    it = (m_st == T_INTRO) ? 3 : 0;
    drive(1'b0, key_lvl, 1'b0, 1'b0, 5, ko, et, it);
    check_model("adv");
  endtask

  task automatic go_play();
    for (int n = 0; n < 8; n++) begin
      if (m_st == T_PLAY) break;
      advance();
    end
    chk("reach_play", int'(ifc.GameState), T_PLAY);
  endtask

  task automatic play_round(input bit h1, input bit h2);
    go_play();
    drive(1'b0, key_lvl, h1, h2, (h1 || h2) ? 5 : 0, 0, 0, 0);
    check_model("round_end");
    for (int n = 0; n < 4; n++) begin
      if (m_st == T_KO || m_st == T_RE) advance();
    end
  endtask

  task automatic press_start();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0, 0);
    check_model("key_low");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0, 0);
    check_model("key_high");
  endtask

  task automatic do_reset(input bit key);
    drive(1'b1, key, 1'b0, 1'b0, 5, 0, 0, 0);
    drive(1'b1, key, 1'b0, 1'b0, 5, 0, 0, 0);
  endtask

  initial begin
    vec_t v;
    tbl.push_back(mk(1,0,0,5,0,0,0, 5,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,5,0,0,0, 9,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,5,0,0,1, 9,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,5,0,0,3, 3,0,0,1,0,0));
    tbl.push_back(mk(1,1,0,5,0,0,0, 6,1,0,1,1,0));
    tbl.push_back(mk(1,0,0,5,1,0,0, 6,1,0,1,1,0));
    tbl.push_back(mk(1,0,0,5,2,0,0, 8,1,0,1,1,0));
    tbl.push_back(mk(1,0,0,5,0,2,0, 5,1,0,2,1,0));
    tbl.push_back(mk(1,0,0,5,0,0,0, 9,1,0,2,1,0));
    tbl.push_back(mk(1,0,0,5,0,0,3, 3,1,0,2,0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0, 6,1,0,2,3,0));
    tbl.push_back(mk(1,0,0,5,2,0,0, 8,1,0,2,3,0));
    tbl.push_back(mk(1,0,0,5,0,2,0, 5,1,0,3,3,0));
    tbl.push_back(mk(1,0,0,5,0,0,0, 9,1,0,3,3,0));
    tbl.push_back(mk(1,0,0,5,0,0,3, 3,1,0,3,0,0));
    tbl.push_back(mk(1,0,0,7,0,0,0, 3,1,0,3,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, 6,1,1,3,2,0));
    tbl.push_back(mk(1,1,0,5,0,0,0, 6,1,1,3,2,0));

    do_reset(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0, 0);
    chk("reset/state", int'(ifc.GameState), T_TITLE);
    chk("reset/p1score", int'(ifc.P1Score), 0);
    chk("reset/p2score", int'(ifc.P2Score), 0);
    chk("reset/round", int'(ifc.RoundNum), 0);
    chk("reset/matchwin", int'(ifc.MatchWinner), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(1'b0, v.key, v.h1, v.h2, v.rt, v.ko, v.et, v.it);
      chk($sformatf("vec%0d/state", i), int'(ifc.GameState), v.st);
      chk($sformatf("vec%0d/p1score", i), int'(ifc.P1Score), v.s1);
      chk($sformatf("vec%0d/p2score", i), int'(ifc.P2Score), v.s2);
      chk($sformatf("vec%0d/round", i), int'(ifc.RoundNum), v.rn);
      chk($sformatf("vec%0d/roundwin", i), int'(ifc.RoundWinner), v.rw);
      chk($sformatf("vec%0d/matchwin", i), int'(ifc.MatchWinner), v.mw);
    end

    // P1 takes three straight rounds
    do_reset(1'b0);
    press_start();
    for (int r = 0; r < 3; r++) play_round(1'b1, 1'b0);
    chk("p1match/state", int'(ifc.GameState), T_MO);
    chk("p1match/matchwin", int'(ifc.MatchWinner), 1);
    chk("p1match/p1score", int'(ifc.P1Score), 3);
    chk("p1match/p2score", int'(ifc.P2Score), 0);
    press_start();
    chk("p1match_title/state", int'(ifc.GameState), T_TITLE);
    chk("p1match_title/p1score", int'(ifc.P1Score), 0);
    chk("p1match_title/round", int'(ifc.RoundNum), 0);
    chk("p1match_title/matchwin", int'(ifc.MatchWinner), 0);

    // seven timeouts force a drawn match
    press_start();
    for (int r = 0; r < 7; r++) begin
      play_round(1'b0, 1'b0);
      chk($sformatf("timeout%0d/roundwin", r), int'(ifc.RoundWinner), 3);
    end
    chk("timeouts/state", int'(ifc.GameState), T_MO);
    chk("timeouts/matchwin", int'(ifc.MatchWinner), 3);
    chk("timeouts/round", int'(ifc.RoundNum), 7);

    // reset in the middle of a KO pause
    press_start();
    press_start();
    go_play();
    drive(1'b0, key_lvl, 1'b0, 1'b1, 5, 0, 0, 0);
    chk("ko_reset_pre/state", int'(ifc.GameState), T_KO);
    chk("ko_reset_pre/p2score", int'(ifc.P2Score), 1);
    drive(1'b1, key_lvl, 1'b0, 1'b0, 5, 0, 0, 0);
    chk("ko_reset/state", int'(ifc.GameState), T_TITLE);
    chk("ko_reset/p2score", int'(ifc.P2Score), 0);
    chk("ko_reset/round", int'(ifc.RoundNum), 0);

    // start key held through reset release must not start a match
    do_reset(1'b1);
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0, 0);
      chk($sformatf("held_key%0d/state", n), int'(ifc.GameState), T_TITLE);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0, 0);
    chk("held_release/state", int'(ifc.GameState), T_TITLE);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0, 0);
    chk("held_repress/state", int'(ifc.GameState), T_SETUP);

    // randomized play against the reference model
    do_reset(1'b0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) key_lvl = ~key_lvl;
      drive($urandom_range(0, 299) == 0, key_lvl,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Match-level state machine for the Divekick game. It produces the 4-bit GameState consumed by the round timer, the three pause timers, the sprite logic and the HUD.
- It consumes the timers' outputs, the per-player hit flags from collision detection, and the start key.
- It tracks round number, per-player round wins and round/match winners.

Parameters:
- WIN_ROUNDS, 3: round wins needed to take the match (1..3).
- MAX_ROUNDS, 7: total rounds played before the match is forced to end (1..7).
- KO_SECS, 2: KO pause exits when ko_time equals this value.
- END_SECS, 2: round-end pause exits when end_time equals this value.
- INTRO_HALVES, 3: intro pause exits when intro_time equals this value (half-second units).

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- StartKey  in  1  start button, level; already synchronised
- P1Hit  in  1  P1 kick connected this cycle (from collision logic)
- P2Hit  in  1  P2 kick connected this cycle
- round_time  in  4  remaining seconds from round timer (15 down to 0)
- ko_time  in  2  KO pause timer, seconds
- end_time  in  2  round-end pause timer, seconds
- intro_time  in  2  intro pause timer, half-seconds
- GameState  out  4  current state code
- P1Score  out  2  P1 round wins
- P2Score  out  2  P2 round wins
- RoundNum  out  3  current round, 1-based; 0 on title
- RoundWinner  out  2  00 none, 01 P1, 10 P2, 11 draw
- MatchWinner  out  2  same encoding; valid in MATCH_OVER

Behaviour:
- State codes:
  - TITLE 0000
  - PLAY 0011
  - SETUP 0101
  - KO_PAUSE 0110
  - ROUND_END 1000
  - INTRO 1001
  - MATCH_OVER 1010
  - All other codes are illegal and return to TITLE next cycle.
- All outputs are registered; each state change is visible one cycle after the causing input.
- Reset: GameState=TITLE; all scores, RoundNum, RoundWinner and MatchWinner = 0. Reset overrides everything, including mid-round.
- Start edge: start_edge = StartKey & ~StartKey_q. StartKey_q resets to 1, so a key held through reset does not trigger a start.
- TITLE:
  - Start edge → SETUP.
  - Same cycle: clear scores, RoundWinner and MatchWinner; RoundNum ← 1.
- SETUP: exactly one cycle, then → INTRO. The round timer reloads to 15 in this state.
- INTRO: when intro_time==INTRO_HALVES → PLAY; RoundWinner ← 00.
- PLAY, in priority order:
  - P1Hit&P2Hit → KO_PAUSE, RoundWinner=11, no score change.
  - P1Hit only → KO_PAUSE, RoundWinner=01, P1Score+1.
  - P2Hit only → KO_PAUSE, RoundWinner=10, P2Score+1.
  - No hit and round_time==0 → ROUND_END, RoundWinner=11. A hit in the same cycle as round_time==0 takes priority over the timeout.
- Hit flags are ignored outside PLAY.
- Scores saturate at 3.
- KO_PAUSE: when ko_time==KO_SECS:
  - P1Score==WIN_ROUNDS or P2Score==WIN_ROUNDS → MATCH_OVER.
  - Otherwise → ROUND_END.
- ROUND_END: when end_time==END_SECS:
  - RoundNum==MAX_ROUNDS → MATCH_OVER.
  - Otherwise → SETUP, RoundNum+1.
- Entering MATCH_OVER: MatchWinner ← 01 if P1Score>P2Score, 10 if P2Score>P1Score, 11 if equal. Scores and RoundNum are held for display.
- MATCH_OVER: start edge → TITLE; all counters clear on that transition.
- Pause timers clear whenever GameState differs from their own state. Each pause therefore starts at 0 on entry, so exit is exactly N timer ticks after entry.

Decomposition:
- Package divekick_pkg holds:
  - the state code constants as a typedef enum logic [3:0];
  - winner codes NONE, P1, P2, DRAW as a 2-bit typedef;
  - shared width constants.
- The package is also imported by the timers and HUD so state codes live in one place.
- One sub-module: rising_edge_det.
  - Ports: Clk, Reset, d, rise.
  - Reset value of the delayed bit is a parameter, set to 1 here.
- Next-state logic and score/round registers stay in game_state_fsm.

Test Plan:
- Reset, then StartKey 0→1 → GameState 0000→0101 (one cycle)→1001; RoundNum=1; scores 0/0.
- In PLAY pulse P1Hit one cycle → GameState 0110, RoundWinner=01, P1Score=1. Set ko_time=2 → 1000. Set end_time=2 → 0101, RoundNum=2.
- P1 wins 3 rounds (P2Hit=0) → after third KO_PAUSE expiry GameState=1010, MatchWinner=01, P1Score=3, P2Score=0. Start edge → 0000, all outputs 0.
- In PLAY assert P1Hit and P2Hit together → 0110, RoundWinner=11, scores unchanged. Separately, assert P2Hit and round_time=0 together → RoundWinner=10, P2Score+1 (hit beats timeout).
- round_time=0 with no hits for 7 consecutive rounds → each round ends via 1000 with RoundWinner=11. After round 7 → 1010, MatchWinner=11.
- Cover both mid-round interruptions:
  - Reset asserted during 0110 → next cycle 0000, scores 0.
  - Hold StartKey high through reset release → stays 0000 until the key is released and pressed again.
